// File: rtl/trap_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trap_ctrl: machine-mode trap/mret sequencer driving CSR strobes and the  |
// | fetch redirect.                                                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trap_ctrl #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_exc_valid,
  input  logic [CAUSE_W-1:0] i_exc_cause,
  input  logic [XLEN-1:0]    i_exc_pc,
  input  logic               i_mret,
  input  logic               i_retire,
  input  logic [XLEN-1:0]    i_next_pc,
  input  logic [XLEN-1:0]    i_mtvec,
  input  logic [XLEN-1:0]    i_mepc,
  input  logic [XLEN-1:0]    i_mie,
  input  logic [XLEN-1:0]    i_mip,
  input  logic               i_mstatus_mie,
  input  logic               i_halted,
  output logic [XLEN-1:0]    o_mepc_data,
  output logic               o_mepc_we,
  output logic [XLEN-1:0]    o_mcause_data,
  output logic               o_mcause_we,
  output logic               o_mie_clear,
  output logic               o_mie_restore,
  output logic               o_redirect,
  output logic [XLEN-1:0]    o_redirect_pc,
  output logic               o_stall,
  output logic [31:0]        o_trap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_SAVE         = 3'd1,
    S_JUMP         = 3'd2,
    S_MRET_RESTORE = 3'd3,
    S_MRET_JUMP    = 3'd4
  } state_t;

  // Timer interrupt cause: interrupt flag in the MSB, code 7.
  localparam logic [XLEN-1:0] c_irq_cause = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(7);

  state_t            r_state;
  state_t            w_next;
  logic [XLEN-1:0]   r_cause;
  logic [XLEN-1:0]   r_epc;
  logic [31:0]       r_trap_cnt;
  logic              w_idle;
  logic              w_irq_pend;
  logic              w_take_exc;
  logic              w_take_mret;
  logic              w_take_irq;
  logic [XLEN-1:0]   w_base;
  logic [XLEN-1:0]   w_vec_off;
  logic [XLEN-1:0]   w_vector;

  assign w_idle      = (r_state == S_IDLE);
  assign w_irq_pend  = i_retire && i_mstatus_mie && !i_halted && (|(i_mie & i_mip));
  assign w_take_exc  = w_idle && i_exc_valid;
  assign w_take_mret = w_idle && !i_exc_valid && i_mret;
  assign w_take_irq  = w_idle && !i_exc_valid && !i_mret && w_irq_pend;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_exc || w_take_irq) w_next = S_SAVE;
        else if (w_take_mret)         w_next = S_MRET_RESTORE;
      end
      S_SAVE:         w_next = S_JUMP;
      S_JUMP:         w_next = S_IDLE;
      S_MRET_RESTORE: w_next = S_MRET_JUMP;
      S_MRET_JUMP:    w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cause    <= '0;
      r_epc      <= '0;
      r_trap_cnt <= '0;
    end else if (w_take_exc) begin
      r_cause    <= {{(XLEN-CAUSE_W){1'b0}}, i_exc_cause};
      r_epc      <= i_exc_pc;
      r_trap_cnt <= r_trap_cnt + 32'd1;
    end else if (w_take_irq) begin
      r_cause    <= c_irq_cause;
      r_epc      <= i_next_pc;
      r_trap_cnt <= r_trap_cnt + 32'd1;
    end
  end

  // Vectored mode only applies to interrupts; modes 2/3 fall back to direct.
  assign w_base    = {i_mtvec[XLEN-1:2], 2'b00};
  assign w_vec_off = {{(XLEN-CAUSE_W-2){1'b0}}, r_cause[CAUSE_W-1:0], 2'b00};
  assign w_vector  = (i_mtvec[1:0] == 2'b01 && r_cause[XLEN-1]) ? (w_base + w_vec_off) : w_base;

  always_comb begin
    o_mepc_we     = 1'b0;
    o_mcause_we   = 1'b0;
    o_mie_clear   = 1'b0;
    o_mie_restore = 1'b0;
    o_redirect    = 1'b0;
    o_redirect_pc = '0;
    o_stall       = !w_idle;
    case (r_state)
      S_SAVE: begin
        o_mepc_we   = 1'b1;
        o_mcause_we = 1'b1;
        o_mie_clear = 1'b1;
      end
      S_JUMP: begin
        o_redirect    = 1'b1;
        o_redirect_pc = w_vector;
      end
      S_MRET_RESTORE: o_mie_restore = 1'b1;
      S_MRET_JUMP: begin
        o_redirect    = 1'b1;
        o_redirect_pc = i_mepc;
      end
      default: ;
    endcase
  end

  assign o_mepc_data   = r_epc;
  assign o_mcause_data = r_cause;
  assign o_trap_cnt    = r_trap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// Testbench for trap_ctrl: directed plan steps plus randomized events checked
// against a transaction-level reference model.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_exc_valid;
  logic [3:0]  i_exc_cause;
  logic [63:0] i_exc_pc;
  logic        i_mret;
  logic        i_retire;
  logic [63:0] i_next_pc;
  logic [63:0] i_mtvec;
  logic [63:0] i_mepc;
  logic [63:0] i_mie;
  logic [63:0] i_mip;
  logic        i_mstatus_mie;
  logic        i_halted;
  logic [63:0] o_mepc_data;
  logic        o_mepc_we;
  logic [63:0] o_mcause_data;
  logic        o_mcause_we;
  logic        o_mie_clear;
  logic        o_mie_restore;
  logic        o_redirect;
  logic [63:0] o_redirect_pc;
  logic        o_stall;
  logic [31:0] o_trap_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_cnt;
  logic [63:0] m_cause;
  logic [63:0] m_epc;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(64), .CAUSE_W(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_exc_valid(i_exc_valid), .i_exc_cause(i_exc_cause), .i_exc_pc(i_exc_pc),
    .i_mret(i_mret), .i_retire(i_retire), .i_next_pc(i_next_pc),
    .i_mtvec(i_mtvec), .i_mepc(i_mepc), .i_mie(i_mie), .i_mip(i_mip),
    .i_mstatus_mie(i_mstatus_mie), .i_halted(i_halted),
    .o_mepc_data(o_mepc_data), .o_mepc_we(o_mepc_we),
    .o_mcause_data(o_mcause_data), .o_mcause_we(o_mcause_we),
    .o_mie_clear(o_mie_clear), .o_mie_restore(o_mie_restore),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_stall(o_stall), .o_trap_cnt(o_trap_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobe vector: {mepc_we, mcause_we, mie_clear, mie_restore, redirect, stall}
  task automatic check_outs(input string tag, input logic [5:0] exp_strb, input logic [63:0] exp_pc);
    check({tag, ".strobes"}, {58'd0, o_mepc_we, o_mcause_we, o_mie_clear, o_mie_restore, o_redirect, o_stall},
          {58'd0, exp_strb});
    check({tag, ".redirect_pc"}, o_redirect_pc, exp_pc);
    check({tag, ".trap_cnt"}, {32'd0, o_trap_cnt}, {32'd0, m_cnt});
    check({tag, ".mepc_data"}, o_mepc_data, m_epc);
    check({tag, ".mcause_data"}, o_mcause_data, m_cause);
  endtask

  task automatic clear_events();
    i_exc_valid = 1'b0; i_mret = 1'b0; i_retire = 1'b0;
  endtask

  // One transaction from IDLE; called just after a falling edge.
  task automatic run_txn(input string tag, input logic exc_v, input logic [3:0] cause,
                         input logic [63:0] epc, input logic mret, input logic retire,
                         input logic [63:0] npc, input logic [63:0] mtvec, input logic [63:0] mepc,
                         input logic [63:0] mie, input logic [63:0] mip, input logic gmie,
                         input logic halted);
    bit is_trap, is_int, is_mret;
    logic [63:0] target;
    i_exc_valid = exc_v; i_exc_cause = cause; i_exc_pc = epc; i_mret = mret;
    i_retire = retire; i_next_pc = npc; i_mtvec = mtvec; i_mepc = mepc;
    i_mie = mie; i_mip = mip; i_mstatus_mie = gmie; i_halted = halted;
    check_outs({tag, ".idle"}, 6'b000000, 64'd0);
    is_int  = !exc_v && !mret && retire && gmie && !halted && ((mie & mip) != 64'd0);
    is_trap = exc_v || is_int;
    is_mret = !exc_v && mret;
    @(posedge clk); @(negedge clk);
    if (is_trap) begin
      m_cnt   = m_cnt + 32'd1;
      m_epc   = exc_v ? epc : npc;
      m_cause = exc_v ? {60'd0, cause} : ((64'd1 << 63) + 64'd7);
    end
    // Events offered while busy must be ignored.
    i_exc_valid = 1'($urandom); i_mret = 1'($urandom); i_retire = 1'($urandom);
    i_mie = '1; i_mip = '1; i_mstatus_mie = 1'b1; i_halted = 1'b0;
    if (is_trap) begin
      check_outs({tag, ".save"}, 6'b111001, 64'd0);
      target = (mtvec / 4) * 4;
      if (is_int && (mtvec % 4) == 1) target = target + 4 * 7;
      @(posedge clk); @(negedge clk);
      check_outs({tag, ".jump"}, 6'b000011, target);
      @(posedge clk); @(negedge clk);
      clear_events();
    end else if (is_mret) begin
      check_outs({tag, ".restore"}, 6'b000101, 64'd0);
      i_mepc = mepc + 64'd0;
      @(posedge clk); @(negedge clk);
      check_outs({tag, ".mret_jump"}, 6'b000011, mepc);
      @(posedge clk); @(negedge clk);
      clear_events();
    end else begin
      clear_events();
      check_outs({tag, ".none"}, 6'b000000, 64'd0);
    end
  endtask

  initial begin
    m_cnt = 0; m_cause = 0; m_epc = 0;
    i_reset = 1'b1; clear_events();
    i_exc_cause = 0; i_exc_pc = 0; i_next_pc = 0; i_mtvec = 0; i_mepc = 0;
    i_mie = 0; i_mip = 0; i_mstatus_mie = 0; i_halted = 0;
    #1;
    check_outs("reset", 6'b000000, 64'd0);
    @(negedge clk); @(negedge clk);
    i_reset = 1'b0;

    run_txn("exc", 1, 4'd2, 64'h1000, 0, 0, 64'h0, 64'h8001, 64'h0, 64'h0, 64'h0, 1, 0);
    run_txn("irq", 0, 4'd0, 64'h0, 0, 1, 64'h2004, 64'h8001, 64'h0, 64'h80, 64'h80, 1, 0);
    run_txn("mret", 0, 4'd0, 64'h0, 1, 0, 64'h0, 64'h8001, 64'h2004, 64'h0, 64'h0, 1, 0);
    run_txn("all3", 1, 4'd5, 64'h3000, 1, 1, 64'h3004, 64'h8001, 64'h2004, 64'h80, 64'h80, 1, 0);
    run_txn("mie0", 0, 4'd0, 64'h0, 0, 1, 64'h4000, 64'h8001, 64'h0, 64'h80, 64'h80, 0, 0);
    run_txn("halted", 0, 4'd0, 64'h0, 0, 1, 64'h4000, 64'h8001, 64'h0, 64'h80, 64'h80, 1, 1);
    run_txn("noret", 0, 4'd0, 64'h0, 0, 0, 64'h4000, 64'h8001, 64'h0, 64'h80, 64'h80, 1, 0);
    run_txn("mode2", 0, 4'd0, 64'h0, 0, 1, 64'h5000, 64'h9002, 64'h0, 64'h80, 64'h80, 1, 0);
    run_txn("mode3", 0, 4'd0, 64'h0, 0, 1, 64'h5008, 64'h9003, 64'h0, 64'h80, 64'h80, 1, 0);
    run_txn("vecwrap", 0, 4'd0, 64'h0, 0, 1, 64'h6000, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 64'h80, 64'h80, 1, 0);

    // Reset in the middle of SAVE aborts immediately.
    i_exc_valid = 1'b1; i_exc_cause = 4'd3; i_exc_pc = 64'h7000;
    @(posedge clk); #1;
    clear_events();
    check("rst_mid.pre_we", {63'd0, o_mepc_we}, 64'd1);
    i_reset = 1'b1; #1;
    m_cnt = 0; m_cause = 0; m_epc = 0;
    check_outs("rst_mid", 6'b000000, 64'd0);
    @(negedge clk);
    i_reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_outs("rst_mid.after", 6'b000000, 64'd0);
    run_txn("post_rst", 1, 4'd4, 64'h7100, 0, 0, 64'h0, 64'hA000, 64'h0, 64'h0, 64'h0, 0, 0);

    // Counter wrap.
    force dut.r_trap_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_trap_cnt;
    m_cnt = 32'hFFFF_FFFF;
    check("wrap.pre", {32'd0, o_trap_cnt}, 64'hFFFF_FFFF);
    run_txn("wrap", 1, 4'd1, 64'h8100, 0, 0, 64'h0, 64'hA000, 64'h0, 64'h0, 64'h0, 0, 0);
    check("wrap.zero", {32'd0, o_trap_cnt}, 64'd0);

    for (int i = 0; i < 300; i++) begin
      logic [63:0] mie_r, mip_r, mtvec_r;
      mie_r   = ($urandom_range(0, 3) != 0) ? 64'h80 : {$urandom, $urandom};
      mip_r   = ($urandom_range(0, 2) != 0) ? 64'h80 : 64'h0;
      mtvec_r = {$urandom, $urandom};
      run_txn("rand", ($urandom_range(0, 4) == 0), 4'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 3) == 0), 1'($urandom), {$urandom, $urandom}, mtvec_r,
              {$urandom, $urandom}, mie_r, mip_r, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
